// File: rtl/ex_mem.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mem
//  Purpose  : EX->MEM pipeline register with stall/bubble/hold/flush handling
//             and the MADD/MSUB intermediate feedback path to EX.
//  Options  : EX_MEM_MADD_EN builds the hilo/cnt feedback flops.
//  Revision : 1.0  initial release
// ============================================================================
module ex_mem (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic        flush,
   input  logic [4:0]  ex_wd,
   input  logic        ex_wreg,
   input  logic [31:0] ex_wdata,
   input  logic        ex_whilo,
   input  logic [31:0] ex_hi,
   input  logic [31:0] ex_lo,
   input  logic [63:0] hilo_i,
   input  logic [1:0]  cnt_i,
   output logic [4:0]  mem_wd,
   output logic        mem_wreg,
   output logic [31:0] mem_wdata,
   output logic        mem_whilo,
   output logic [31:0] mem_hi,
   output logic [31:0] mem_lo,
   output logic [63:0] hilo_o,
   output logic [1:0]  cnt_o
);

   logic w_advance;
   logic w_bubble;

   // Hold is implied when neither advance nor bubble applies (EX and MEM both stalled).
   assign w_advance = ~stall[3];
   assign w_bubble  = stall[3] & ~stall[4];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_wd    <= 5'd0;
         mem_wreg  <= 1'b0;
         mem_wdata <= 32'd0;
         mem_whilo <= 1'b0;
         mem_hi    <= 32'd0;
         mem_lo    <= 32'd0;
      end else if (flush || w_bubble) begin
         mem_wd    <= 5'd0;
         mem_wreg  <= 1'b0;
         mem_wdata <= 32'd0;
         mem_whilo <= 1'b0;
         mem_hi    <= 32'd0;
         mem_lo    <= 32'd0;
      end else if (w_advance) begin
         mem_wd    <= ex_wd;
         mem_wreg  <= ex_wreg;
         mem_wdata <= ex_wdata;
         mem_whilo <= ex_whilo;
         mem_hi    <= ex_hi;
         mem_lo    <= ex_lo;
      end
   end

`ifdef EX_MEM_MADD_EN
   // The intermediate product survives only while EX sits stalled mid-MADD/MSUB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hilo_o <= 64'd0;
         cnt_o  <= 2'd0;
      end else if (flush || w_advance) begin
         hilo_o <= 64'd0;
         cnt_o  <= 2'd0;
      end else if (w_bubble) begin
         hilo_o <= hilo_i;
         cnt_o  <= cnt_i;
      end
   end

   logic unused_stall_bits;
   assign unused_stall_bits = ^{stall[5], stall[2:0]};
`else
   assign hilo_o = 64'd0;
   assign cnt_o  = 2'd0;

   logic unused_madd_inputs;
   assign unused_madd_inputs = ^{hilo_i, cnt_i, stall[5], stall[2:0]};
`endif

endmodule
`default_nettype wire
